seg7_scan_display: RTL and testbench

- Downstream display stage of the MIPS FPGA top.
- Takes the Show selector and the four 32-bit statistic/data words produced by the CPU core (LED data, total cycle count, taken-branch count, jump count).
- Time-multiplexes the selected word as 8 hex digits onto the board's active-low 8-digit seven-segment display, driving the SEG/AN pins of the top.
- The displayed word is snapshotted once per full scan so that digits never tear while counters run.

---
 rtl/seg7_scan_display_pkg.sv | 24 ++
 rtl/seg7_scan_display_if.sv | 23 ++
 rtl/seg7_scan_display_hex_to_seg7.sv | 11 +
 rtl/seg7_scan_display.sv | 88 ++++++++
 tb/tb_seg7_scan_display.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/seg7_scan_display_pkg.sv
// Shared definitions for the seven-segment scan display: source selector codes,
// the blank pattern and the hex digit to active-low segment table.
package seg7_pkg;

    typedef enum logic [2:0] {
        SHOW_LED    = 3'd0,
        SHOW_ALL    = 3'd1,
        SHOW_BRANCH = 3'd2,
        SHOW_JMP    = 3'd3
    } show_sel_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry n is the {g,f,e,d,c,b,a} pattern for hex digit n; a segment lights when its bit is 0.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] nibble_to_seg(input logic [3:0] nibble);
        return HEX_SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// Bundle between the CPU statistics sources and the scan display: the selector,
// the four candidate words and the SEG/AN pins driven back out to the board.
interface seg7_scan_display_if;

    logic [2:0]  Show;
    logic [31:0] Leddata;
    logic [31:0] countAll;
    logic [31:0] Count_branch;
    logic [31:0] countJmp;
    logic [7:0]  SEG;
    logic [7:0]  AN;

    modport master (
        output Show, Leddata, countAll, Count_branch, countJmp,
        input  SEG, AN
    );

    modport slave (
        input  Show, Leddata, countAll, Count_branch, countJmp,
        output SEG, AN
    );

endinterface

// File: rtl/seg7_scan_display_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern ({g,f,e,d,c,b,a}).
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = nibble_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexes one of four 32-bit words as 8 hex digits on an active-low display,
// latching the word once per full scan so digits never mix two counter values.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter bit LZ_BLANK = 1'b0
) (
    input  logic                clk,
    input  logic                clr,
    seg7_scan_display_if.slave  bus
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] prescaler;
    logic [2:0]    idx;
    logic [31:0]   snapshot;
    logic          snap_invalid;
    logic          load_pending;
    logic          tick;
    logic          do_load;
    logic [31:0]   selected_word;
    logic [4:0]    digit_lsb;
    logic [3:0]    nibble;
    logic [6:0]    hex_pattern;
    logic [6:0]    seg_pattern;
    logic          leading_zero;

    assign tick      = (prescaler == PRESCALE_LAST);
    assign do_load   = load_pending | (tick & (idx == 3'd7));
    assign digit_lsb = {idx, 2'b00};

    always_comb begin
        selected_word = 32'h0;
        case (bus.Show)
            SHOW_LED:    selected_word = bus.Leddata;
            SHOW_ALL:    selected_word = bus.countAll;
            SHOW_BRANCH: selected_word = bus.Count_branch;
            SHOW_JMP:    selected_word = bus.countJmp;
            default:     selected_word = 32'h0;
        endcase
    end

    assign nibble       = snapshot[digit_lsb +: 4];
    assign leading_zero = (idx != 3'd0) && ((snapshot >> digit_lsb) == 32'h0);

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble),
        .seg    (hex_pattern)
    );

    assign seg_pattern = (LZ_BLANK && leading_zero) ? SEG_BLANK : hex_pattern;

    // Slot timing and the once-per-scan snapshot; the load on the idx 7 tick lands
    // exactly as digit 0 comes back round, so a scan never straddles two words.
    always_ff @(posedge clk) begin
        if (clr) begin
            prescaler    <= '0;
            idx          <= 3'd0;
            snapshot     <= 32'h0;
            snap_invalid <= 1'b0;
            load_pending <= 1'b1;
        end else begin
            prescaler <= tick ? '0 : prescaler + PW'(1);
            if (tick) begin
                idx <= (idx == 3'd7) ? 3'd0 : idx + 3'd1;
            end
            if (do_load) begin
                snapshot     <= selected_word;
                snap_invalid <= (bus.Show > 3'd3);
                load_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            bus.AN  <= 8'hFF;
            bus.SEG <= 8'hFF;
        end else begin
            bus.AN  <= ~(8'b1 << idx);
            bus.SEG <= {~snap_invalid, seg_pattern};
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench: two displays (leading zeros shown / blanked) against an
// edge-count model of the scan, plus hand-computed digit patterns.
module tb_seg7_scan_display;

    localparam int SD  = 4;
    localparam int PER = 8 * SD;

    logic        clk = 1'b0;
    logic        clr;
    logic [2:0]  show;
    logic [31:0] leddata, count_all, count_branch, count_jmp;

    int checks   = 0;
    int failures = 0;

    seg7_scan_display_if bus0 ();
    seg7_scan_display_if bus1 ();

    assign bus0.Show = show;         assign bus1.Show = show;
    assign bus0.Leddata = leddata;   assign bus1.Leddata = leddata;
    assign bus0.countAll = count_all;        assign bus1.countAll = count_all;
    assign bus0.Count_branch = count_branch; assign bus1.Count_branch = count_branch;
    assign bus0.countJmp = count_jmp;        assign bus1.countJmp = count_jmp;

    seg7_scan_display #(.SCAN_DIV(SD), .LZ_BLANK(1'b0)) dut0 (.clk(clk), .clr(clr), .bus(bus0));
    seg7_scan_display #(.SCAN_DIV(SD), .LZ_BLANK(1'b1)) dut1 (.clk(clk), .clr(clr), .bus(bus1));

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [31:0] pick(input logic [2:0] s);
        case (s)
            3'd0: return leddata;
            3'd1: return count_all;
            3'd2: return count_branch;
            3'd3: return count_jmp;
            default: return 32'h0;
        endcase
    endfunction

    // Model: k counts edges since clr dropped; edge k shows digit ((k-1)/SD)%8 of the
    // word latched on edge 1 or on the last edge of each full period.
    int          k = 0;
    bit          model_valid = 1'b0;
    logic [31:0] m_snap;
    logic        m_inv;
    logic [7:0]  exp_an, exp_seg0, exp_seg1;

    always @(posedge clk) begin
        int d;
        logic [6:0] pat;
        if (clr) begin
            k = 0; m_snap = 32'h0; m_inv = 1'b0;
            exp_an = 8'hFF; exp_seg0 = 8'hFF; exp_seg1 = 8'hFF;
            model_valid = 1'b1;
        end else begin
            k++;
            d = ((k - 1) / SD) % 8;
            exp_an = ~(8'd1 << d);
            pat = seg_of(4'(m_snap >> (4 * d)));
            exp_seg0 = {~m_inv, pat};
            exp_seg1 = {~m_inv, (d > 0 && (m_snap >> (4 * d)) == 32'h0) ? 7'h7F : pat};
            if (k == 1 || k % PER == 0) begin
                m_snap = pick(show);
                m_inv  = (show > 3'd3);
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check_output("an0", bus0.AN, exp_an);
            check_output("seg0", bus0.SEG, exp_seg0);
            check_output("an1", bus1.AN, exp_an);
            check_output("seg1", bus1.SEG, exp_seg1);
        end
    end

    // Step to the first negedge of a new period, where digit 0 of a fresh load shows.
    task automatic align_period;
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(k > 1 && k % PER == 1) && n < 4 * PER);
        if (n >= 4 * PER) begin
            checks++;
            failures++;
            $display("[TB] FAIL align timeout: got k=%0d expected period start", k);
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] s, input logic [31:0] led);
        show    = s;
        leddata = led;
    endtask

    logic [7:0] lit_scan [8] = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
    logic [7:0] lit_lz   [8] = '{8'h92, 8'h88, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    initial begin
        clr = 1'b1;
        count_all = 32'h0; count_branch = 32'h0; count_jmp = 32'hCAFE_0003;
        apply_stimulus(3'd0, 32'h89AB_CDEF);

        repeat (3) begin
            @(negedge clk);
            check_output("rst_an", bus0.AN, 8'hFF);
            check_output("rst_seg", bus0.SEG, 8'hFF);
        end
        clr = 1'b0;
        @(negedge clk);
        check_output("first_an", bus0.AN, 8'hFE);
        check_output("first_seg", bus0.SEG, 8'hC0);

        @(negedge clk);
        for (int d = 0; d < 8; d++) begin
            check_output("scan_an", bus0.AN, ~(8'd1 << d));
            check_output("scan_seg0", bus0.SEG, lit_scan[d]);
            check_output("scan_seg1", bus1.SEG, lit_scan[d]);
            repeat (SD) @(negedge clk);
        end

        // Running counter with a selector change mid-scan
        show = 3'd1;
        for (int i = 0; i < 3 * PER; i++) begin
            @(negedge clk);
            count_all = count_all + 32'd1;
            if (i == PER + 10) show = 3'd3;
        end

        align_period();
        show = 3'd5;
        align_period();
        for (int d = 0; d < 8; d++) begin
            check_output("inv_seg", bus0.SEG, 8'h40);
            repeat (SD) @(negedge clk);
        end
        show = 3'd2; count_branch = 32'h1234_5678;
        align_period();
        check_output("br_an", bus0.AN, 8'hFE);
        check_output("br_seg", bus0.SEG, 8'h80);

        apply_stimulus(3'd0, 32'h0000_00A5);
        align_period();
        for (int d = 0; d < 8; d++) begin
            check_output("lz_an", bus1.AN, ~(8'd1 << d));
            check_output("lz_seg", bus1.SEG, lit_lz[d]);
            repeat (SD) @(negedge clk);
        end
        apply_stimulus(3'd0, 32'h0);
        align_period();
        check_output("lz0_seg", bus1.SEG, 8'hC0);
        repeat (SD) @(negedge clk);
        check_output("lz0_blank", bus1.SEG, 8'hFF);
        check_output("lz0_an", bus1.AN, 8'hFD);

        align_period();
        repeat (5 * SD) @(negedge clk);
        check_output("mid_an", bus0.AN, 8'hDF);
        clr = 1'b1;
        @(negedge clk);
        check_output("mid_rst_an", bus0.AN, 8'hFF);
        check_output("mid_rst_seg", bus0.SEG, 8'hFF);
        clr = 1'b0;
        leddata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_output("re_an", bus0.AN, 8'hFE);
        check_output("re_seg", bus0.SEG, 8'hC0);
        @(negedge clk);
        check_output("re_seg_load", bus0.SEG, 8'h8E);
        repeat (PER + 4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
